// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder family: FSM state encoding and the
// inactive output pattern helper.
// Pure declarations, no logic.
package decoder_pkg;

  // Upper bound on decoder output count supported by the pattern helper
  localparam int MAX_OUT = 256;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STATIC = 2'd1;
  localparam state_t ST_SCAN   = 2'd2;
  localparam state_t ST_GAP    = 2'd3;

  // All-inactive level for `width` outputs: all ones when active-low, else zero.
  // Bits above `width` are zero; callers slice the low `width` bits.
  function automatic logic [MAX_OUT-1:0] inactive_pat(input int width, input bit active_low);
    logic [MAX_OUT-1:0] pat;
    pat = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (i < width) pat[i] = active_low;
    end
    return pat;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W -> 2^SEL_W one-hot decoder, active-high.
// Zero latency; no flow control.
// Shared by the decoder family; polarity is applied by the caller.
module decoder_onehot #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel_i,
  output logic [(1<<SEL_W)-1:0] y_o
);

  // Set exactly the selected bit
  always_comb begin
    y_o        = '0;
    y_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// One-hot decoder with registered outputs: STATIC decodes i_sel, SCAN sequences 0..i_last
// with a programmable dwell and BLANK inactive cycles between channels.
// Outputs change one clock after the inputs that cause them; no backpressure.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 16,
  parameter int BLANK      = 1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_opt,
  input  logic [DIV_W-1:0]      i_dwell,
  input  logic [SEL_W-1:0]      i_last,
  output logic [(1<<SEL_W)-1:0] o_y,
  output logic [SEL_W-1:0]      o_idx,
  output logic                  o_valid,
  output logic                  o_wrap
);

  localparam int OUT_N    = 1 << SEL_W;
  localparam int GAP_LAST = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  localparam logic [GAP_W-1:0]   GAP_END   = GAP_LAST[GAP_W-1:0];
  localparam logic [MAX_OUT-1:0] INACT_ALL = inactive_pat(OUT_N, ACTIVE_LOW);
  localparam logic [OUT_N-1:0]   INACT     = INACT_ALL[OUT_N-1:0];

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               wrap_d;

  logic [OUT_N-1:0]   y_q, y_d;
  logic               valid_q, valid_d;
  logic               wrap_q;

  logic [SEL_W-1:0]   idx_adv;
  logic               wraps;
  logic [OUT_N-1:0]   onehot;

  // Next channel in the scan; >= so a lowered i_last wraps instead of running on
  assign wraps   = (idx_q >= i_last);
  assign idx_adv = wraps ? '0 : idx_q + 1'b1;

  decoder_onehot #(
    .SEL_W (SEL_W)
  ) u_onehot (
    .sel_i (idx_d),
    .y_o   (onehot)
  );

  // State and counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Next state: enable and mode override the dwell/gap sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    wrap_d  = 1'b0;
    if (!i_en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      gap_d   = '0;
    end else if (!i_mode) begin
      state_d = ST_STATIC;
      idx_d   = i_sel;
      cnt_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          // >= lets a shortened dwell end the channel at once rather than wrap the counter
          if (cnt_q >= i_dwell) begin
            cnt_d = '0;
            if (BLANK > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else begin
              idx_d  = idx_adv;
              wrap_d = wraps;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_END) begin
            state_d = ST_SCAN;
            idx_d   = idx_adv;
            wrap_d  = wraps;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          // IDLE or STATIC entering SCAN always restarts at channel 0
          state_d = ST_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
          gap_d   = '0;
        end
      endcase
    end
  end

  // Output pattern for the next state: polarity-adjusted one-hot or inactive, then optional invert
  always_comb begin
    valid_d = (state_d == ST_STATIC) || (state_d == ST_SCAN);
    y_d     = valid_d ? (ACTIVE_LOW ? ~onehot : onehot) : INACT;
    y_d     = y_d ^ {OUT_N{i_opt}};
  end

  // Output register; reset forces the inactive level regardless of i_opt
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      y_q     <= INACT;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_y     = y_q;
  assign o_idx   = idx_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances (BLANK=1 and BLANK=0) share stimulus and are
// compared every cycle against a slot-based reference model, plus directed scenarios.
// Outputs are sampled on the falling edge.
module tb_decoder_scan;

  localparam bit AL = 1'b1;
  localparam int K_IDLE = 0, K_STATIC = 1, K_SCAN = 2;

  logic        clk = 1'b0;
  logic        rst, en, mode, opt;
  logic [2:0]  sel, last;
  logic [15:0] dwell;

  logic [7:0] y0, y1;
  logic [2:0] idx0, idx1;
  logic       val0, val1, wrap0, wrap1;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state per instance
  int       m_kind[2];
  int       m_ch[2];
  int       m_age[2];
  int       m_gap[2];
  logic [7:0] ex_y[2];
  int       ex_idx[2];
  bit       ex_val[2];
  bit       ex_wrap[2];

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .DIV_W(16), .BLANK(1), .ACTIVE_LOW(AL)) dut_b1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sel(sel), .i_opt(opt),
    .i_dwell(dwell), .i_last(last), .o_y(y0), .o_idx(idx0), .o_valid(val0), .o_wrap(wrap0)
  );

  decoder_scan #(.SEL_W(3), .DIV_W(16), .BLANK(0), .ACTIVE_LOW(AL)) dut_b0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sel(sel), .i_opt(opt),
    .i_dwell(dwell), .i_last(last), .o_y(y1), .o_idx(idx1), .o_valid(val1), .o_wrap(wrap1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_out(input int k);
    bit act;
    logic [7:0] oh, pat;
    act = (m_kind[k] == K_STATIC) || (m_kind[k] == K_SCAN && m_gap[k] == 0);
    oh  = 8'h01 << m_ch[k];
    pat = act ? (AL ? ~oh : oh) : {8{AL}};
    ex_y[k]   = pat ^ {8{opt}};
    ex_idx[k] = m_ch[k];
    ex_val[k] = act;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_kind[k] = K_IDLE; m_ch[k] = 0; m_age[k] = 0; m_gap[k] = 0;
      ex_y[k] = {8{AL}}; ex_idx[k] = 0; ex_val[k] = 1'b0; ex_wrap[k] = 1'b0;
    end
  endtask

  task automatic model_advance(input int k);
    m_age[k] = 0;
    if (m_ch[k] >= int'(last)) begin
      m_ch[k] = 0;
      ex_wrap[k] = 1'b1;
    end else begin
      m_ch[k] = m_ch[k] + 1;
    end
  endtask

  // One channel slot = dwell+1 active cycles followed by `blank` dark cycles
  task automatic model_step(input int k, input int blank);
    ex_wrap[k] = 1'b0;
    if (!en) begin
      m_kind[k] = K_IDLE; m_ch[k] = 0; m_age[k] = 0; m_gap[k] = 0;
    end else if (!mode) begin
      m_kind[k] = K_STATIC; m_ch[k] = int'(sel); m_age[k] = 0; m_gap[k] = 0;
    end else if (m_kind[k] != K_SCAN) begin
      m_kind[k] = K_SCAN; m_ch[k] = 0; m_age[k] = 0; m_gap[k] = 0;
    end else if (m_gap[k] > 0) begin
      m_gap[k] = m_gap[k] - 1;
      if (m_gap[k] == 0) model_advance(k);
    end else if (m_age[k] >= int'(dwell)) begin
      m_age[k] = 0;
      if (blank > 0) m_gap[k] = blank;
      else model_advance(k);
    end else begin
      m_age[k] = m_age[k] + 1;
    end
    model_out(k);
  endtask

  // Advance one clock, update the model, then compare both instances on the falling edge
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0, 1);
      model_step(1, 0);
    end
    @(negedge clk);
    check_eq("y_b1",     32'(y0),    32'(ex_y[0]));
    check_eq("idx_b1",   32'(idx0),  32'(ex_idx[0]));
    check_eq("valid_b1", 32'(val0),  32'(ex_val[0]));
    check_eq("wrap_b1",  32'(wrap0), 32'(ex_wrap[0]));
    check_eq("y_b0",     32'(y1),    32'(ex_y[1]));
    check_eq("idx_b0",   32'(idx1),  32'(ex_idx[1]));
    check_eq("valid_b0", 32'(val1),  32'(ex_val[1]));
    check_eq("wrap_b0",  32'(wrap1), 32'(ex_wrap[1]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    bit found;

    rst = 1'b1; en = 1'b0; mode = 1'b0; opt = 1'b1; sel = '0; last = '0; dwell = '0;
    model_reset();
    #3;
    // Reset state, i_opt ignored
    check_eq("rst_y",     32'(y0),    32'hFF);
    check_eq("rst_valid", 32'(val0),  32'h0);
    check_eq("rst_idx",   32'(idx0),  32'h0);
    check_eq("rst_wrap",  32'(wrap0), 32'h0);
    cycle();
    cycle();
    rst = 1'b0; opt = 1'b0; en = 1'b1; mode = 1'b0;

    // STATIC decode of every channel
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      e = 8'h01 << s;
      e = ~e;
      check_eq("static_y", 32'(y0), 32'(e));
    end
    sel = 3'd3; opt = 1'b1;
    cycle();
    check_eq("static_opt", 32'(y0), 32'h08);

    // SCAN dwell=2 last=3 BLANK=1: 3 active + 1 dark per channel, wrap every 16
    opt = 1'b0; mode = 1'b1; dwell = 16'd2; last = 3'd3;
    for (int c = 0; c < 33; c++) begin
      cycle();
      e = 8'h01 << ((c / 4) % 4);
      e = ((c % 4) < 3) ? ~e : 8'hFF;
      check_eq("scan3_y", 32'(y0), 32'(e));
      check_eq("scan3_wrap", 32'(wrap0), 32'((c > 0) && (c % 16 == 0)));
    end

    // SCAN dwell=0 last=7 BLANK=0: one channel per cycle, wrap every 8
    mode = 1'b0;
    cycle();
    mode = 1'b1; dwell = 16'd0; last = 3'd7;
    for (int c = 0; c < 32; c++) begin
      cycle();
      check_eq("fast_idx",  32'(idx1), 32'(c % 8));
      check_eq("fast_wrap", 32'(wrap1), 32'((c > 0) && (c % 8 == 0)));
      check_eq("fast_one",  32'($countones(~y1)), 32'd1);
    end

    // Lower i_last below the current channel
    dwell = 16'd1;
    found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      cycle();
      if (idx0 == 3'd5) found = 1'b1;
    end
    check_eq("t5_reach5", 32'(found), 32'd1);
    last = 3'd2;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle();
      if (idx0 != 3'd5) found = 1'b1;
    end
    check_eq("t5_left5", 32'(found), 32'd1);
    check_eq("t5_idx",   32'(idx0),  32'd0);
    check_eq("t5_wrap",  32'(wrap0), 32'd1);

    // Disable during a gap, re-enable, then switch to STATIC mid-dwell
    last = 3'd7; dwell = 16'd3;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (!val0) found = 1'b1;
    end
    check_eq("t6_gap", 32'(found), 32'd1);
    en = 1'b0;
    cycle();
    check_eq("t6_idle_y", 32'(y0), 32'hFF);
    check_eq("t6_idle_v", 32'(val0), 32'd0);
    en = 1'b1;
    cycle();
    check_eq("t6_re_idx", 32'(idx0), 32'd0);
    check_eq("t6_re_y",   32'(y0),   32'hFE);
    cycle();
    mode = 1'b0; sel = 3'd5;
    cycle();
    check_eq("t6_static_y", 32'(y0), 32'hDF);

    // Asynchronous reset mid-scan
    mode = 1'b1; dwell = 16'd2; last = 3'd0;
    for (int c = 0; c < 6; c++) cycle();
    rst = 1'b1;
    #1;
    check_eq("arst_y",    32'(y0),    32'hFF);
    check_eq("arst_v",    32'(val0),  32'd0);
    check_eq("arst_wrap", 32'(wrap0), 32'd0);
    cycle();
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      en  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) last = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) dwell = 16'($urandom_range(0, 3));
      sel = 3'($urandom_range(0, 7));
      opt = ($urandom_range(0, 7) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
